// File: rtl/usb_pkg.sv
// usb_pkg: shared types and defaults for the USB transmit path
package usb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_EOP
   } bs_state_e;

   localparam int STUFF_LEN_DEF = 6;

endpackage

// File: rtl/counter.sv
// counter: saturating up-counter with synchronous clear (clear wins over increment)
module counter #(
   parameter int W   = 4,
   parameter int MAX = (1 << W) - 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = clr ? '0 : (inc && count_q != W'(MAX)) ? count_q + W'(1) : count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/bit_stuffer.sv
// bit_stuffer: inserts a 0 after STUFF_LEN consecutive 1s, stalling the encoder
// with pause, then hands off to the EOP stage once endr is seen.
module bit_stuffer
   import usb_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic endr,
   input  logic s_in,
   output logic pause,
   output logic s_out,
   output logic bit_valid,
   output logic eop_req,
   input  logic eop_done,
   output logic busy
);

   localparam int RW = $clog2(STUFF_LEN + 1);

   bs_state_e     state_q, state_d;
   logic          s_out_q, s_out_d;
   logic          bit_valid_q, bit_valid_d;
   logic          eop_req_q, eop_req_d;
   logic          run_clr, run_inc;
   logic [RW-1:0] run;

   counter #(.W(RW), .MAX(STUFF_LEN)) u_run (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (run_clr),
      .inc   (run_inc),
      .count (run)
   );

   // A pending stuff takes priority over endr so the final run is still terminated.
   always_comb begin
      pause       = state_q == ST_SEND && run == RW'(STUFF_LEN);
      state_d     = state_q;
      s_out_d     = 1'b0;
      bit_valid_d = 1'b0;
      run_clr     = 1'b0;
      run_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SEND;
               run_clr = 1'b1;
            end
         end
         ST_SEND: begin
            if (pause) begin
               bit_valid_d = 1'b1;
               run_clr     = 1'b1;
            end else if (endr) begin
               state_d = ST_EOP;
            end else begin
               s_out_d     = s_in;
               bit_valid_d = 1'b1;
               run_inc     = s_in;
               run_clr     = !s_in;
            end
         end
         ST_EOP: begin
            if (eop_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      eop_req_d = state_d == ST_EOP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         s_out_q     <= 1'b0;
         bit_valid_q <= 1'b0;
         eop_req_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_out_q     <= s_out_d;
         bit_valid_q <= bit_valid_d;
         eop_req_q   <= eop_req_d;
      end
   end

   assign s_out     = s_out_q;
   assign bit_valid = bit_valid_q;
   assign eop_req   = eop_req_q;
   assign busy      = state_q != ST_IDLE;

endmodule

// File: tb/tb_bit_stuffer.sv
// tb_bit_stuffer: directed packets with hand-computed stuffed streams, checked
// by a scoreboard monitor that pops one expected bit per valid output.
module tb_bit_stuffer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, endr = 1'b0, s_in = 1'b0, eop_done = 1'b0;
   logic pause, s_out, bit_valid, eop_req, busy;

   int   n_vec = 0, n_err = 0;
   int   cyc = 0, start_cyc = 0, first_cyc = -1, pause_cnt = 0;
   int   pause_cyc[$];
   logic sb[$];

   bit_stuffer #(.STUFF_LEN(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .endr      (endr),
      .s_in      (s_in),
      .pause     (pause),
      .s_out     (s_out),
      .bit_valid (bit_valid),
      .eop_req   (eop_req),
      .eop_done  (eop_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (pause) begin
            pause_cnt++;
            pause_cyc.push_back(cyc);
         end
         if (bit_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_extra: got valid s_out=%0b, required no valid bit (cycle %0d)", s_out, cyc);
            end else begin
               chk("s_out", int'(s_out), int'(sb.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) sb.push_back(v[i]);
   endtask

   task automatic begin_pkt();
      pause_cnt = 0;
      pause_cyc.delete();
      first_cyc = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         s_in = v[i];
         for (int g = 0; g < 4 && pause; g++) tick();
         tick();
      end
   endtask

   task automatic end_pkt(input int dly, input bit poke_start);
      endr = 1'b1;
      for (int g = 0; g < 20 && !eop_req; g++) tick();
      chk("eop_req_rise", int'(eop_req), 1);
      chk("sb_drained_at_eop", sb.size(), 0);
      for (int c = 0; c < dly; c++) begin
         chk("eop_req_held", int'(eop_req), 1);
         chk("busy_in_eop", int'(busy), 1);
         chk("no_valid_in_eop", int'(bit_valid), 0);
         start = poke_start && c == 1;
         tick();
         start = 1'b0;
      end
      eop_done = 1'b1;
      chk("busy_before_done_edge", int'(busy), 1);
      tick();
      eop_done = 1'b0;
      endr = 1'b0;
      chk("busy_after_done", int'(busy), 0);
      chk("eop_req_after_done", int'(eop_req), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(bit_valid), 0);
      chk("rst_eop_req", int'(eop_req), 0);
      chk("rst_pause", int'(pause), 0);
      @(negedge clk);
      rst_n = 1'b1;
      s_in = 1'b1;
      endr = 1'b1;
      eop_done = 1'b1;
      tick();
      tick();
      chk("idle_ignores_busy", int'(busy), 0);
      chk("idle_ignores_valid", int'(bit_valid), 0);
      chk("idle_ignores_eop", int'(eop_req), 0);
      s_in = 1'b0;
      endr = 1'b0;
      eop_done = 1'b0;
      tick();

      // seven 1s then 0: stuff after the sixth
      expect_bits(32'b111111010, 9);
      begin_pkt();
      send_bits(32'b11111110, 8);
      end_pkt(1, 1'b0);
      chk("t1_pause_cnt", pause_cnt, 1);
      chk("t1_pause_cyc", pause_cyc.size() > 0 ? pause_cyc[0] - start_cyc : -1, 6);

      // handshake pattern: no stuffing, latency 1
      expect_bits(32'b0000000111010010, 16);
      begin_pkt();
      send_bits(32'b0000000111010010, 16);
      end_pkt(1, 1'b0);
      chk("t2_pause_cnt", pause_cnt, 0);
      chk("t2_latency", first_cyc - start_cyc, 1);

      // ends in six 1s: stuff coincides with endr
      expect_bits(32'b0101111110, 10);
      begin_pkt();
      send_bits(32'b010111111, 9);
      end_pkt(2, 1'b0);
      chk("t3_pause_cnt", pause_cnt, 1);

      // twelve 1s: two stuffs seven cycles apart
      expect_bits(32'b11111101111110, 14);
      begin_pkt();
      send_bits(32'hFFF, 12);
      end_pkt(1, 1'b0);
      chk("t4_pause_cnt", pause_cnt, 2);
      chk("t4_pause_gap", pause_cyc.size() > 1 ? pause_cyc[1] - pause_cyc[0] : -1, 7);

      // reset mid-SEND, then a clean packet must start with run at 0
      expect_bits(32'b111, 3);
      begin_pkt();
      send_bits(32'b111, 3);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_async_busy", int'(busy), 0);
      chk("t5_async_valid", int'(bit_valid), 0);
      chk("t5_async_sout", int'(s_out), 0);
      chk("t5_async_eop", int'(eop_req), 0);
      chk("t5_async_pause", int'(pause), 0);
      s_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("t5_idle_after_rst", int'(busy), 0);
      chk("t5_sb_empty", sb.size(), 0);
      expect_bits(32'b11111100, 8);
      begin_pkt();
      send_bits(32'b1111110, 7);
      end_pkt(1, 1'b0);
      chk("t5_pause_cnt", pause_cnt, 1);
      chk("t5_pause_cyc", pause_cyc.size() > 0 ? pause_cyc[0] - start_cyc : -1, 6);

      // slow eop_done with a stray start during EOP
      expect_bits(32'b10, 2);
      begin_pkt();
      send_bits(32'b10, 2);
      end_pkt(5, 1'b1);
      tick();
      tick();
      chk("t6_start_ignored_busy", int'(busy), 0);
      chk("t6_start_ignored_valid", int'(bit_valid), 0);
      chk("t6_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
